// File: rtl/uart_pkg.sv
// Shared types and helpers for the burst UART transmitter.
// Frame length accounts for the optional parity bit (UART_TX_PARITY_EN).
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP,
    S_DONE
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int uart_frame_len(input int baud_div, input int data_w, input int stop_bits);
`ifdef UART_TX_PARITY_EN
    return (2 + data_w + stop_bits) * baud_div;
`else
    return (1 + data_w + stop_bits) * baud_div;
`endif
  endfunction

endpackage

// File: rtl/uart_burst_tx_bit_shifter.sv
// uart_bit_shifter: loads a payload word and shifts it out LSB first.
// Even parity over the loaded word is kept when UART_TX_PARITY_EN is defined.
module uart_bit_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_shift,
  output logic              o_bit,
  output logic              o_next_bit,
  output logic              o_last
`ifdef UART_TX_PARITY_EN
  ,
  output logic              o_parity
`endif
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_shreg <= i_word;
      r_idx   <= '0;
    end else if (i_shift) begin
      r_shreg <= r_shreg >> 1;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_parity <= 1'b0;
    else if (i_load) r_parity <= ^i_word;
  end

  assign o_parity = r_parity;
`endif

  // o_next_bit lets the caller register tx in the same edge as the shift.
  assign o_bit      = r_shreg[0];
  assign o_next_bit = r_shreg[1];
  assign o_last     = (r_idx == LAST_IDX);

endmodule

// File: rtl/uart_burst_tx.sv
// uart_burst_tx: sends num_bytes UART frames per start request with a programmable gap.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_burst_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 868,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int GAP_W     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic              system_clock,
  input  logic              cpu_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  num_bytes,
  input  logic [GAP_W-1:0]  gap_bits,
  input  logic              incr_mode,
  input  logic              abort,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              byte_strobe,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);

  tx_state_t         r_state, w_next_state;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [GAP_W-1:0]  r_gap_cnt, r_gap;
  logic              r_stop_idx;
  logic [DATA_W-1:0] r_payload;
  logic [CNT_W-1:0]  r_num, r_byte_count;
  logic              r_incr, r_tx, r_busy, r_done, r_strobe;

  logic              w_tick, w_last_stop, w_accept, w_reload;
  logic              w_count_up, w_load, w_shift, w_tx_next;
  logic              w_cur_bit, w_next_bit, w_last_bit;
  logic [CNT_W-1:0]  w_count_inc;
`ifdef UART_TX_PARITY_EN
  logic              w_parity;
`endif

  assign w_tick      = (r_baud_cnt == '0);
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_count_inc = r_byte_count + CNT_W'(1);
  assign w_reload    = (r_state == S_IDLE) || w_tick || (w_next_state != r_state);

  uart_bit_shifter #(.DATA_W(DATA_W)) u_shifter (
    .i_clk      (system_clock),
    .i_rst_n    (cpu_rst_n),
    .i_load     (w_load),
    .i_word     (r_payload),
    .i_shift    (w_shift),
    .o_bit      (w_cur_bit),
    .o_next_bit (w_next_bit),
    .o_last     (w_last_bit)
`ifdef UART_TX_PARITY_EN
    ,
    .o_parity   (w_parity)
`endif
  );

  always_ff @(posedge system_clock) begin
    if (!cpu_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_count_up   = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_tx_next    = UART_IDLE_LEVEL;
    case (r_state)
      S_IDLE:  if (start) w_next_state = (num_bytes == '0) ? S_DONE : S_START;
      S_START: if (w_tick) begin
        w_next_state = S_DATA;
        w_load       = 1'b1;
      end
      S_DATA:  if (w_tick) begin
        if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end else begin
          w_shift = 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_tick) w_next_state = S_STOP;
`endif
      S_STOP:  if (w_tick && w_last_stop) begin
        w_count_up = 1'b1;
        if (w_count_inc == r_num) w_next_state = S_DONE;
        else if (r_gap == '0)     w_next_state = S_START;
        else                      w_next_state = S_GAP;
      end
      S_GAP:   if (w_tick && (r_gap_cnt == '0)) w_next_state = S_START;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    // Abort beats a frame ending in the same cycle: nothing is counted.
    if ((r_state != S_IDLE) && abort) begin
      w_next_state = S_IDLE;
      w_count_up   = 1'b0;
      w_load       = 1'b0;
      w_shift      = 1'b0;
    end
    case (w_next_state)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_load ? r_payload[0] : (w_shift ? w_next_bit : w_cur_bit);
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = w_parity;
`endif
      default:  w_tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (!cpu_rst_n) begin
      r_tx         <= UART_IDLE_LEVEL;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_strobe     <= 1'b0;
      r_byte_count <= '0;
      r_payload    <= '0;
      r_num        <= '0;
      r_gap        <= '0;
      r_incr       <= 1'b0;
      r_baud_cnt   <= BAUD_RELOAD;
      r_gap_cnt    <= '0;
      r_stop_idx   <= 1'b0;
    end else begin
      r_tx     <= w_tx_next;
      r_busy   <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
      r_done   <= (r_state == S_DONE) && !abort;
      r_strobe <= w_count_up;
      if (w_accept) begin
        r_payload    <= data_in;
        r_num        <= num_bytes;
        r_gap        <= gap_bits;
        r_incr       <= incr_mode;
        r_byte_count <= '0;
      end else if (w_count_up) begin
        r_byte_count <= w_count_inc;
        if (r_incr) r_payload <= r_payload + DATA_W'(1);
      end
      if (w_reload) r_baud_cnt <= BAUD_RELOAD;
      else          r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
      if ((w_next_state == S_GAP) && (r_state != S_GAP)) r_gap_cnt <= r_gap - GAP_W'(1);
      else if ((r_state == S_GAP) && w_tick)             r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      if (r_state != S_STOP) r_stop_idx <= 1'b0;
      else if (w_tick)       r_stop_idx <= 1'b1;
    end
  end

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign byte_strobe = r_strobe;
  assign byte_count  = r_byte_count;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Directed bench for uart_burst_tx with BAUD_DIV=4, DATA_W=8; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_burst_tx;
  import uart_pkg::*;

  localparam int BAUD = 4;
  localparam int DW   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT     = 1;
  localparam int DONE_LAT = 45;
`else
  localparam int PBIT     = 0;
  localparam int DONE_LAT = 41;
`endif
  localparam int F_LEN = (10 + PBIT) * BAUD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        incr_mode = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  data_in = '0;
  logic [15:0] num_bytes = '0;
  logic [3:0]  gap_bits = '0;
  logic        tx, busy, done, byte_strobe;
  logic [15:0] byte_count;

  logic [7:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;

  always #5 clk = ~clk;

  uart_burst_tx #(
    .BAUD_DIV(BAUD), .DATA_W(DW), .CNT_W(16), .GAP_W(4), .STOP_BITS(1)
  ) dut (
    .system_clock(clk), .cpu_rst_n(rst_n), .start(start), .data_in(data_in),
    .num_bytes(num_bytes), .gap_bits(gap_bits), .incr_mode(incr_mode), .abort(abort),
    .tx(tx), .busy(busy), .done(done), .byte_strobe(byte_strobe), .byte_count(byte_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":tx"}, tx, 1);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":strobe"}, byte_strobe, 0);
    check({tag, ":count"}, byte_count, 0);
  endtask

  // Line level at cycle c of a frame carrying word w.
  function automatic logic exp_bit(input logic [7:0] w, input int c);
    int b;
    b = c / BAUD;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (PBIT == 1 && b == DW + 1) return ^w;
    return 1'b1;
  endfunction

  // Launch a burst and check every output on every cycle up to the done pulse.
  task automatic run_burst(input string tag, input logic [7:0] d, input int n, input int g, input logic inc);
    int per, t_end, cnt_e, k, c;
    logic [7:0] w;
    per   = F_LEN + g * BAUD;
    t_end = n * F_LEN + (n - 1) * g * BAUD;
    for (int j = 0; j < n; j++) exp_q.push_back(inc ? 8'(d + 8'(j)) : d);
    data_in = d; num_bytes = 16'(n); gap_bits = 4'(g); incr_mode = inc; start = 1'b1;
    tick();
    start = 1'b0; data_in = ~d; num_bytes = '0; gap_bits = '0; incr_mode = ~inc;
    w = exp_q.pop_front();
    for (int t = 0; t <= t_end; t++) begin
      k = t / per;
      c = t % per;
      if (c == 0 && t > 0 && k < n) w = exp_q.pop_front();
      cnt_e = (t >= F_LEN) ? ((t - F_LEN) / per + 1) : 0;
      if (cnt_e > n) cnt_e = n;
      check({tag, ":tx"}, tx, (k < n && c < F_LEN) ? exp_bit(w, c) : 1'b1);
      check({tag, ":busy"}, busy, (t < t_end) ? 1 : 0);
      check({tag, ":strobe"}, byte_strobe, (t >= F_LEN && (t - F_LEN) % per == 0) ? 1 : 0);
      check({tag, ":count"}, byte_count, cnt_e);
      check({tag, ":done_early"}, done, 0);
      tick();
    end
    check({tag, ":done"}, done, 1);
    check({tag, ":busy_end"}, busy, 0);
    tick();
    check({tag, ":done_once"}, done, 0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    run_burst("single_a5", 8'hA5, 1, 0, 1'b0);
    run_burst("incr_fe", 8'hFE, 3, 2, 1'b1);
    run_burst("gap0_x2", 8'h10, 2, 0, 1'b0);

    // Empty burst: done one cycle after the start edge, line never drops.
    data_in = 8'h5A; num_bytes = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("empty:tx0", tx, 1);
    check("empty:busy", busy, 0);
    check("empty:done_early", done, 0);
    tick();
    check("empty:done", done, 1);
    check("empty:tx1", tx, 1);
    check("empty:count", byte_count, 0);
    tick();
    check("empty:done_once", done, 0);

    // Abort inside frame 2 data bits.
    data_in = 8'h3C; num_bytes = 16'd5; gap_bits = '0; incr_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (F_LEN + 14) tick();
    check("abort:count_before", byte_count, 1);
    check("abort:busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort:tx", tx, 1);
    check("abort:busy", busy, 0);
    check("abort:count", byte_count, 1);
    check("abort:strobe", byte_strobe, 0);
    repeat (3) begin
      tick();
      check("abort:no_done", done, 0);
      check("abort:tx_idle", tx, 1);
    end

    // Abort on the final stop cycle: the frame is not counted.
    data_in = 8'h81; num_bytes = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (F_LEN - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_end:count", byte_count, 0);
    check("abort_end:strobe", byte_strobe, 0);
    check("abort_end:busy", busy, 0);
    tick();
    check("abort_end:no_done", done, 0);

    // Start while busy is ignored.
    data_in = 8'h55; num_bytes = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (10) begin
      tick();
      lat++;
    end
    data_in = 8'h00; num_bytes = 16'd3; start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 500) begin
      tick();
      lat++;
    end
    check("busy_start:done_lat", lat, DONE_LAT);
    check("busy_start:count", byte_count, 1);

    // Start one cycle after done launches a new burst.
    tick();
    data_in = 8'hC3; num_bytes = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("relaunch:tx", tx, 0);
    check("relaunch:busy", busy, 1);

    // Synchronous reset in the middle of the stop bit.
    repeat (F_LEN - 3) tick();
    check("mid_stop:tx", tx, 1);
    rst_n = 1'b0;
    tick();
    check_reset_vals("mid_stop_rst");
    rst_n = 1'b1;
    tick();

    run_burst("single_07", 8'h07, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
